// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  // Arbiter FSM states: idle, waiting on a fetch access, waiting on a data access.
  typedef enum logic [1:0] {
    IDLE,
    WAIT_IF,
    WAIT_D
  } arb_state_t;

  // Identifies which requester was granted most recently.
  typedef enum logic {
    GNT_IF,
    GNT_D
  } grant_t;

  // Read data returned to a requester whose access timed out.
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_watchdog.sv
// Wait-state watchdog: reloads on clear, counts down once per enabled cycle,
// and flags expiry on the TIMEOUT-th wait cycle after the clear.
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt;

  // Down-counter: the first wait cycle sees TIMEOUT-1, the last one sees zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= CW'(TIMEOUT - 1);
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch port and the data port,
// runs the req/ack handshake with a watchdog, and raises pipeline stall requests.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                err
);

  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_t          state, state_nx;
  grant_t              last_grant, last_grant_nx;
  logic                mem_req_nx, mem_we_nx;
  logic [BE_W-1:0]     mem_be_nx;
  logic [ADDR_W-1:0]   mem_addr_nx;
  logic [DATA_W-1:0]   mem_wdata_nx, if_rdata_nx, d_rdata_nx;
  logic                if_ready_nx, d_ready_nx, err_nx;
  logic                elig_if, elig_d, grant, wd_en, expire;

  // A requester in its ready cycle is still holding req; mask it so it is not re-granted.
  assign elig_if   = if_req & ~if_ready;
  assign elig_d    = d_req & ~d_ready;
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = d_req & ~d_ready;

  assign wd_en = (state != IDLE) && !mem_ack;

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clear (grant),
    .enable(wd_en),
    .expire(expire)
  );

  // Next-state: grant selection in IDLE, completion or abort in the wait states.
  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    mem_req_nx    = mem_req;
    mem_we_nx     = mem_we;
    mem_be_nx     = mem_be;
    mem_addr_nx   = mem_addr;
    mem_wdata_nx  = mem_wdata;
    if_rdata_nx   = if_rdata;
    d_rdata_nx    = d_rdata;
    if_ready_nx   = 1'b0;
    d_ready_nx    = 1'b0;
    err_nx        = 1'b0;
    grant         = 1'b0;
    case (state)
      IDLE: begin
        if (elig_if || elig_d) begin
          grant      = 1'b1;
          mem_req_nx = 1'b1;
          // On a conflict the side not served last wins; last_grant resets to IF.
          if (elig_d && (!elig_if || (last_grant == GNT_IF))) begin
            state_nx      = WAIT_D;
            last_grant_nx = GNT_D;
            mem_we_nx     = d_we;
            mem_be_nx     = d_be;
            mem_addr_nx   = d_addr;
            mem_wdata_nx  = d_wdata;
          end else begin
            state_nx      = WAIT_IF;
            last_grant_nx = GNT_IF;
            mem_we_nx     = 1'b0;
            mem_be_nx     = '1;
            mem_addr_nx   = if_addr;
            mem_wdata_nx  = '0;
          end
        end
      end
      WAIT_IF: begin
        // An ack arriving in the expiry cycle still counts as a normal completion.
        if (mem_ack) begin
          mem_req_nx  = 1'b0;
          if_rdata_nx = mem_rdata;
          if_ready_nx = 1'b1;
          state_nx    = IDLE;
        end else if (expire) begin
          mem_req_nx  = 1'b0;
          if_rdata_nx = DATA_W'(ERR_DATA);
          if_ready_nx = 1'b1;
          err_nx      = 1'b1;
          state_nx    = IDLE;
        end
      end
      WAIT_D: begin
        if (mem_ack) begin
          mem_req_nx = 1'b0;
          if (!mem_we) d_rdata_nx = mem_rdata;
          d_ready_nx = 1'b1;
          state_nx   = IDLE;
        end else if (expire) begin
          mem_req_nx = 1'b0;
          if (!mem_we) d_rdata_nx = DATA_W'(ERR_DATA);
          d_ready_nx = 1'b1;
          err_nx     = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: begin
        state_nx   = IDLE;
        mem_req_nx = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops mem_req immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GNT_IF;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      mem_req    <= mem_req_nx;
      mem_we     <= mem_we_nx;
      mem_be     <= mem_be_nx;
      mem_addr   <= mem_addr_nx;
      mem_wdata  <= mem_wdata_nx;
      if_rdata   <= if_rdata_nx;
      d_rdata    <= d_rdata_nx;
      if_ready   <= if_ready_nx;
      d_ready    <= d_ready_nx;
      err        <= err_nx;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of arbitration and memory contents.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req, d_req, d_we, mem_ack;
  logic [AW-1:0] if_addr, d_addr;
  logic [3:0]    d_be;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic          if_ready, d_ready, mem_req, mem_we, stall_if, stall_mem, err;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_be     (d_be),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ready  (d_ready),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_be   (mem_be),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .stall_if (stall_if),
    .stall_mem(stall_mem),
    .err      (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0;
    d_wdata = '0; mem_ack = 0; mem_rdata = '0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    merge = old;
    for (int b = 0; b < 4; b++) if (be[b]) merge[8*b +: 8] = wd[8*b +: 8];
  endfunction

  task automatic test_reset();
    idle_inputs(); rst = 1; tick(); tick();
    n_total++; if ({mem_req, mem_we, if_ready, d_ready, err} !== 5'b0) $display("FAIL reset_ctrl: got %b want 00000", {mem_req, mem_we, if_ready, d_ready, err}); else n_pass++;
    n_total++; if ({mem_addr, mem_wdata, mem_be} !== '0) $display("FAIL reset_mem_bus: addr %h wdata %h be %b want 0", mem_addr, mem_wdata, mem_be); else n_pass++;
    n_total++; if ({if_rdata, d_rdata} !== '0) $display("FAIL reset_rdata: if %h d %h want 0", if_rdata, d_rdata); else n_pass++;
    n_total++; if ({stall_if, stall_mem} !== 2'b00) $display("FAIL reset_stall: got %b want 00", {stall_if, stall_mem}); else n_pass++;
    rst = 0; tick();
  endtask

  task automatic test_single_fetch();
    if_req = 1; if_addr = 32'h40;
    tick();
    n_total++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'hF, 32'h40, 32'h0}) $display("FAIL fetch_issue: req %b we %b be %b addr %h wdata %h", mem_req, mem_we, mem_be, mem_addr, mem_wdata); else n_pass++;
    tick(); tick();
    n_total++; if ({mem_req, stall_if, if_ready} !== 3'b110) $display("FAIL fetch_wait3: req/stall/ready %b want 110", {mem_req, stall_if, if_ready}); else n_pass++;
    mem_ack = 1; mem_rdata = 32'h13;
    tick(); mem_ack = 0; mem_rdata = '0;
    n_total++; if ({if_ready, err, mem_req, stall_if} !== 4'b1000) $display("FAIL fetch_ready: ready/err/req/stall %b want 1000", {if_ready, err, mem_req, stall_if}); else n_pass++;
    n_total++; if (if_rdata !== 32'h13) $display("FAIL fetch_rdata: got %h want 00000013", if_rdata); else n_pass++;
    tick();
    n_total++; if ({if_ready, mem_req} !== 2'b00) $display("FAIL fetch_no_regrant: ready/req %b want 00", {if_ready, mem_req}); else n_pass++;
    if_req = 0;
    tick();
  endtask

  task automatic test_conflict();
    rst = 1; tick(); rst = 0;
    if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h100;
    tick();
    n_total++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h100}) $display("FAIL conflict_data_first: req %b we %b addr %h want 1 0 100", mem_req, mem_we, mem_addr); else n_pass++;
    mem_ack = 1; mem_rdata = 32'h1111_1111;
    tick(); mem_ack = 0;
    n_total++; if ({d_ready, if_ready, mem_req, stall_mem, stall_if} !== 5'b10001) $display("FAIL conflict_d_ready: dr/ir/req/smem/sif %b want 10001", {d_ready, if_ready, mem_req, stall_mem, stall_if}); else n_pass++;
    n_total++; if (d_rdata !== 32'h1111_1111) $display("FAIL conflict_d_rdata: got %h want 11111111", d_rdata); else n_pass++;
    tick(); d_req = 0;
    n_total++; if ({mem_req, mem_addr} !== {1'b1, 32'h80}) $display("FAIL conflict_if_second: req %b addr %h want 1 80", mem_req, mem_addr); else n_pass++;
    mem_ack = 1; mem_rdata = 32'h2222_2222;
    tick(); mem_ack = 0;
    n_total++; if ({if_ready, if_rdata} !== {1'b1, 32'h2222_2222}) $display("FAIL conflict_if_ready: ready %b rdata %h want 1 22222222", if_ready, if_rdata); else n_pass++;
    tick(); if_req = 0; d_req = 1; d_addr = 32'h104;
    tick();
    mem_ack = 1; mem_rdata = 32'h3333_3333;
    tick(); mem_ack = 0;
    tick(); d_addr = 32'h108; if_req = 1; if_addr = 32'h8C;
    tick();
    n_total++; if ({mem_req, mem_addr} !== {1'b1, 32'h8C}) $display("FAIL alternation_if_first: req %b addr %h want 1 8c", mem_req, mem_addr); else n_pass++;
    mem_ack = 1; mem_rdata = 32'h4444_4444;
    tick(); mem_ack = 0;
    tick(); if_req = 0;
    n_total++; if ({mem_req, mem_addr} !== {1'b1, 32'h108}) $display("FAIL alternation_d_next: req %b addr %h want 1 108", mem_req, mem_addr); else n_pass++;
    mem_ack = 1; mem_rdata = 32'h5555_5555;
    tick(); mem_ack = 0;
    n_total++; if ({d_ready, d_rdata} !== {1'b1, 32'h5555_5555}) $display("FAIL alternation_d_ready: ready %b rdata %h want 1 55555555", d_ready, d_rdata); else n_pass++;
    tick(); d_req = 0;
  endtask

  task automatic test_store();
    logic [31:0] held;
    held = d_rdata;
    d_req = 1; d_we = 1; d_be = 4'b0011; d_wdata = 32'hAABB_CCDD; d_addr = 32'h200;
    tick();
    n_total++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {2'b11, 4'b0011, 32'h200, 32'hAABB_CCDD}) $display("FAIL store_issue: req %b we %b be %b addr %h wdata %h", mem_req, mem_we, mem_be, mem_addr, mem_wdata); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if ({mem_req, mem_we, mem_be, mem_wdata} !== {2'b11, 4'b0011, 32'hAABB_CCDD}) $display("FAIL store_stable: req %b we %b be %b wdata %h", mem_req, mem_we, mem_be, mem_wdata); else n_pass++;
    end
    mem_ack = 1; mem_rdata = 32'h5A5A_5A5A;
    tick(); mem_ack = 0;
    n_total++; if ({d_ready, err} !== 2'b10) $display("FAIL store_ready: ready/err %b want 10", {d_ready, err}); else n_pass++;
    n_total++; if (d_rdata !== held) $display("FAIL store_rdata_held: got %h want %h", d_rdata, held); else n_pass++;
    tick(); d_req = 0; d_we = 0; d_be = 4'hF;
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h300;
    tick();
    for (int i = 0; i < 20 && d_ready !== 1'b1; i++) begin
      if (mem_req) n++;
      tick();
    end
    n_total++; if (d_ready !== 1'b1) $display("FAIL timeout_d_ready: no ready within bound"); else n_pass++;
    n_total++; if (n != TO) $display("FAIL timeout_req_cycles: got %0d want %0d", n, TO); else n_pass++;
    n_total++; if ({err, mem_req, d_rdata} !== {2'b10, 32'hDEAD_BEEF}) $display("FAIL timeout_d_err: err %b req %b rdata %h want 1 0 deadbeef", err, mem_req, d_rdata); else n_pass++;
    tick(); d_req = 0;
    n_total++; if ({err, d_ready} !== 2'b00) $display("FAIL timeout_pulse: err/ready %b want 00", {err, d_ready}); else n_pass++;
    if_req = 1; if_addr = 32'h50;
    tick();
    for (int i = 0; i < 20 && if_ready !== 1'b1; i++) tick();
    n_total++; if ({if_ready, err, if_rdata} !== {2'b11, 32'hDEAD_BEEF}) $display("FAIL timeout_if: ready %b err %b rdata %h want 1 1 deadbeef", if_ready, err, if_rdata); else n_pass++;
    tick(); if_req = 0;
  endtask

  task automatic test_ack_at_expiry();
    d_req = 1; d_we = 0; d_addr = 32'h304;
    tick();
    repeat (TO - 1) tick();
    n_total++; if (mem_req !== 1'b1) $display("FAIL expiry_still_waiting: req %b want 1", mem_req); else n_pass++;
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    tick(); mem_ack = 0;
    n_total++; if ({d_ready, err, d_rdata} !== {2'b10, 32'h1234_5678}) $display("FAIL expiry_ack_wins: ready %b err %b rdata %h want 1 0 12345678", d_ready, err, d_rdata); else n_pass++;
    tick(); d_req = 0;
  endtask

  task automatic test_reset_mid_wait();
    d_req = 1; d_we = 0; d_addr = 32'h400;
    tick();
    if_req = 1; if_addr = 32'h44;
    tick();
    #2 rst = 1;
    #1;
    n_total++; if (mem_req !== 1'b0) $display("FAIL rst_async_req: got %b want 0", mem_req); else n_pass++;
    n_total++; if ({mem_we, if_ready, d_ready, err, mem_addr, mem_wdata, mem_be, if_rdata, d_rdata} !== '0) $display("FAIL rst_async_outputs: addr %h if_rdata %h d_rdata %h", mem_addr, if_rdata, d_rdata); else n_pass++;
    mem_ack = 1; mem_rdata = 32'h9999_9999; d_req = 0;
    tick();
    rst = 0; mem_ack = 0;
    tick();
    n_total++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h44}) $display("FAIL rst_then_fetch: req %b we %b addr %h want 1 0 44", mem_req, mem_we, mem_addr); else n_pass++;
    mem_ack = 1; mem_rdata = 32'h77;
    tick(); mem_ack = 0;
    n_total++; if ({if_ready, err, if_rdata} !== {2'b10, 32'h77}) $display("FAIL rst_then_fetch_ready: ready %b err %b rdata %h", if_ready, err, if_rdata); else n_pass++;
    tick(); if_req = 0;
  endtask

  task automatic test_random();
    logic [31:0] ref_mem  [8];
    logic [31:0] phys_mem [8];
    logic [31:0] exp_d;
    int   last_srv, infl, dly, n_gnt, exp_g;
    logic ack_q, prev_req, if_rdy_q, d_rdy_q, pe_if, pe_d, idle_prev;
    bit   issue;
    for (int i = 0; i < 8; i++) begin
      ref_mem[i]  = $urandom();
      phys_mem[i] = ref_mem[i];
    end
    idle_inputs(); rst = 1; tick(); rst = 0;
    last_srv = 0; infl = -1; dly = 0; n_gnt = 0; exp_d = '0;
    ack_q = 0; prev_req = 0; if_rdy_q = 0; d_rdy_q = 0; pe_if = 0; pe_d = 0; idle_prev = 1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      issue = (cyc < 1440);
      n_total++; if (if_ready !== (ack_q && infl == 0)) $display("FAIL rnd_if_ready: cyc %0d got %b want %b", cyc, if_ready, ack_q && infl == 0); else n_pass++;
      n_total++; if (d_ready !== (ack_q && infl == 1)) $display("FAIL rnd_d_ready: cyc %0d got %b want %b", cyc, d_ready, ack_q && infl == 1); else n_pass++;
      n_total++; if (err !== 1'b0) $display("FAIL rnd_err: cyc %0d got %b want 0", cyc, err); else n_pass++;
      if (if_ready && infl == 0) begin
        n_total++; if (if_rdata !== ref_mem[if_addr[4:2]]) $display("FAIL rnd_if_rdata: cyc %0d got %h want %h", cyc, if_rdata, ref_mem[if_addr[4:2]]); else n_pass++;
        infl = -1;
      end
      if (d_ready && infl == 1) begin
        if (d_we) ref_mem[d_addr[4:2]] = merge(ref_mem[d_addr[4:2]], d_wdata, d_be);
        else exp_d = ref_mem[d_addr[4:2]];
        n_total++; if (d_rdata !== exp_d) $display("FAIL rnd_d_rdata: cyc %0d got %h want %h", cyc, d_rdata, exp_d); else n_pass++;
        infl = -1;
      end
      if (idle_prev && (pe_if || pe_d)) begin
        n_total++; if (mem_req !== 1'b1) $display("FAIL rnd_missed_grant: cyc %0d req %b want 1", cyc, mem_req); else n_pass++;
      end
      if (mem_req && !prev_req) begin
        exp_g = (pe_if && pe_d) ? 1 - last_srv : (pe_d ? 1 : 0);
        n_total++;
        if (!(pe_if || pe_d)) $display("FAIL rnd_spurious_grant: cyc %0d addr %h", cyc, mem_addr);
        else if (exp_g == 0 && {mem_addr, mem_we, mem_be, mem_wdata} !== {if_addr, 1'b0, 4'hF, 32'h0}) $display("FAIL rnd_grant_if: cyc %0d addr %h we %b want addr %h", cyc, mem_addr, mem_we, if_addr);
        else if (exp_g == 1 && {mem_addr, mem_we, mem_be, mem_wdata} !== {d_addr, d_we, d_be, d_wdata}) $display("FAIL rnd_grant_d: cyc %0d addr %h we %b be %b want addr %h we %b be %b", cyc, mem_addr, mem_we, mem_be, d_addr, d_we, d_be);
        else n_pass++;
        last_srv = exp_g; infl = exp_g; n_gnt++; dly = $urandom_range(0, 4);
      end
      // memory side: acks after a random delay, occasionally a stray ack while idle
      ack_q = 0; mem_ack = 0;
      if (mem_req && infl >= 0) begin
        if (dly == 0) begin
          mem_ack = 1; ack_q = 1;
          if (mem_we) begin
            phys_mem[mem_addr[4:2]] = merge(phys_mem[mem_addr[4:2]], mem_wdata, mem_be);
            mem_rdata = $urandom();
          end else mem_rdata = phys_mem[mem_addr[4:2]];
        end else dly--;
      end else if (!mem_req && $urandom_range(0, 7) == 0) begin
        mem_ack = 1; mem_rdata = $urandom();
      end
      // requesters: hold through the ready cycle, then drop or issue a new request
      if (if_rdy_q || (!if_req && $urandom_range(0, 2) == 0)) begin
        if (issue && (!if_rdy_q || $urandom_range(0, 1) == 1)) begin
          if_req = 1; if_addr = 32'h1000 + 32'($urandom_range(0, 7) * 4);
        end else if_req = 0;
      end
      if (d_rdy_q || (!d_req && $urandom_range(0, 2) == 0)) begin
        if (issue && (!d_rdy_q || $urandom_range(0, 1) == 1)) begin
          d_req = 1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom_range(1, 15));
          d_addr = 32'h1000 + 32'($urandom_range(0, 7) * 4); d_wdata = $urandom();
        end else d_req = 0;
      end
      if_rdy_q = if_ready; d_rdy_q = d_ready;
      pe_if = if_req & ~if_ready; pe_d = d_req & ~d_ready;
      idle_prev = (infl < 0); prev_req = mem_req;
      #1;
      n_total++; if ({stall_if, stall_mem} !== {if_req & ~if_ready, d_req & ~d_ready}) $display("FAIL rnd_stall: cyc %0d got %b want %b", cyc, {stall_if, stall_mem}, {if_req & ~if_ready, d_req & ~d_ready}); else n_pass++;
      tick();
    end
    n_total++; if (n_gnt < 50) $display("FAIL rnd_progress: grants %0d want >= 50", n_gnt); else n_pass++;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_single_fetch();
    test_conflict();
    test_store();
    test_timeout();
    test_ack_at_expiry();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_time_limit: run did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
